// File: rtl/sal_rd_dfi_capture_if.sv
// Read-return bundle for sal_rd_dfi_capture: scheduler issue records, DFI read beats,
// AXI R channel and sticky error flags.
interface sal_rd_dfi_capture_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
);
  logic                  rd_issue_valid;
  logic                  rd_issue_ready;
  logic [ID_WIDTH-1:0]   rd_issue_id;
  logic [3:0]            rd_issue_len;
  logic                  dfi_rddata_valid;
  logic [DATA_WIDTH-1:0] dfi_rddata;
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  err_overflow;
  logic                  err_orphan;

  modport slave (
    input  rd_issue_valid, rd_issue_id, rd_issue_len,
    input  dfi_rddata_valid, dfi_rddata, rready,
    output rd_issue_ready, rvalid, rid, rdata, rresp, rlast,
    output err_overflow, err_orphan
  );

  modport master (
    output rd_issue_valid, rd_issue_id, rd_issue_len,
    output dfi_rddata_valid, dfi_rddata, rready,
    input  rd_issue_ready, rvalid, rid, rdata, rresp, rlast,
    input  err_overflow, err_orphan
  );
endinterface

// File: rtl/sal_rd_dfi_capture.sv
// DDR2 read-return path: tags issued reads, captures DFI beats into a FWFT buffer and
// replays them in order on AXI R. Issue-time reservation keeps the PHY side backpressure-free.
module sal_rd_dfi_capture #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_DEPTH  = 8,
  parameter int DATA_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  sal_rd_dfi_capture_if.slave bus
);
  localparam int TAW = $clog2(TAG_DEPTH);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int CW  = DAW + 1;

  logic [ID_WIDTH-1:0]   r_tag_id  [TAG_DEPTH];
  logic [3:0]            r_tag_len [TAG_DEPTH];
  logic [TAW:0]          r_tag_wptr, r_tag_rptr;
  logic [DATA_WIDTH-1:0] r_data_mem [DATA_DEPTH];
  logic [DAW:0]          r_data_wptr, r_data_rptr;
  logic [CW-1:0]         r_resv_cnt, r_rx_pending;
  logic [3:0]            r_beat_cnt;
  logic                  r_err_overflow, r_err_orphan;

  logic          w_tag_empty, w_tag_full, w_data_empty, w_data_full;
  logic [CW-1:0] w_burst_beats;
  logic [CW:0]   w_need;
  logic          w_issue_ready, w_accept;
  logic          w_rvalid, w_rlast, w_hs;
  logic          w_dfi_take, w_data_push;
  logic [3:0]    w_head_len;

  assign w_tag_empty  = (r_tag_wptr == r_tag_rptr);
  assign w_tag_full   = (r_tag_wptr == {~r_tag_rptr[TAW], r_tag_rptr[TAW-1:0]});
  assign w_data_empty = (r_data_wptr == r_data_rptr);
  assign w_data_full  = (r_data_wptr == {~r_data_rptr[DAW], r_data_rptr[DAW-1:0]});

  assign w_burst_beats = CW'(bus.rd_issue_len) + CW'(1);
  assign w_need        = {1'b0, r_resv_cnt} + {1'b0, w_burst_beats};
  assign w_issue_ready = !w_tag_full && (w_need <= (CW+1)'(DATA_DEPTH));
  assign w_accept      = bus.rd_issue_valid && w_issue_ready;

  assign w_head_len = r_tag_len[r_tag_rptr[TAW-1:0]];
  assign w_rvalid   = !w_data_empty;
  assign w_rlast    = w_rvalid && (r_beat_cnt == w_head_len);
  assign w_hs       = w_rvalid && bus.rready;

  // A pop in the same cycle frees the slot, so a full buffer can still take the beat.
  assign w_dfi_take  = bus.dfi_rddata_valid && (r_rx_pending != '0);
  assign w_data_push = w_dfi_take && (!w_data_full || w_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_wptr     <= '0;
      r_tag_rptr     <= '0;
      r_data_wptr    <= '0;
      r_data_rptr    <= '0;
      r_resv_cnt     <= '0;
      r_rx_pending   <= '0;
      r_beat_cnt     <= '0;
      r_err_overflow <= 1'b0;
      r_err_orphan   <= 1'b0;
    end else begin
      r_resv_cnt   <= r_resv_cnt + (w_accept ? w_burst_beats : '0) - (w_hs ? CW'(1) : '0);
      r_rx_pending <= r_rx_pending + (w_accept ? w_burst_beats : '0) - (w_dfi_take ? CW'(1) : '0);
      if (w_accept)
        r_tag_wptr <= r_tag_wptr + 1'b1;
      if (w_data_push)
        r_data_wptr <= r_data_wptr + 1'b1;
      if (bus.dfi_rddata_valid && (r_rx_pending == '0))
        r_err_orphan <= 1'b1;
      if (w_dfi_take && !w_data_push)
        r_err_overflow <= 1'b1;
      if (w_hs) begin
        r_data_rptr <= r_data_rptr + 1'b1;
        if (w_rlast) begin
          r_tag_rptr <= r_tag_rptr + 1'b1;
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_id[r_tag_wptr[TAW-1:0]]  <= bus.rd_issue_id;
      r_tag_len[r_tag_wptr[TAW-1:0]] <= bus.rd_issue_len;
    end
    if (w_data_push)
      r_data_mem[r_data_wptr[DAW-1:0]] <= bus.dfi_rddata;
  end

  // Storage is not reset, so head fields are masked while nothing is presented.
  assign bus.rd_issue_ready = w_issue_ready;
  assign bus.rvalid         = w_rvalid;
  assign bus.rdata          = w_rvalid ? r_data_mem[r_data_rptr[DAW-1:0]] : '0;
  assign bus.rid            = (w_rvalid && !w_tag_empty) ? r_tag_id[r_tag_rptr[TAW-1:0]] : '0;
  assign bus.rlast          = w_rlast;
  assign bus.rresp          = 2'b00;
  assign bus.err_overflow   = r_err_overflow;
  assign bus.err_orphan     = r_err_orphan;
endmodule

// File: tb/tb_sal_rd_dfi_capture.sv
// Directed bench for sal_rd_dfi_capture with an in-order R-channel scoreboard.
module tb_sal_rd_dfi_capture;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic        last;
  } exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] len;
  } tag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  tag_t tag_q[$];
  int   mcnt = 0;

  always #5 clk = ~clk;

  sal_rd_dfi_capture_if #(.ID_WIDTH(4), .DATA_WIDTH(64)) bif ();

  sal_rd_dfi_capture #(
    .ID_WIDTH(4), .DATA_WIDTH(64), .TAG_DEPTH(8), .DATA_DEPTH(16)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [3:0] len);
    bif.rd_issue_valid = 1'b1;
    bif.rd_issue_id    = id;
    bif.rd_issue_len   = len;
    for (int i = 0; i < 200; i++) begin
      if (bif.rd_issue_ready) break;
      tick();
    end
    chk("issue_ready", 64'(bif.rd_issue_ready), 64'd1);
    tick();
    bif.rd_issue_valid = 1'b0;
    tag_q.push_back('{id: id, len: len});
  endtask

  task automatic beat(input logic [63:0] d);
    exp_t e;
    bif.dfi_rddata_valid = 1'b1;
    bif.dfi_rddata       = d;
    if (tag_q.size() != 0) begin
      e.id   = tag_q[0].id;
      e.data = d;
      e.last = (mcnt == int'(tag_q[0].len));
      exp_q.push_back(e);
      if (e.last) begin
        void'(tag_q.pop_front());
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
    tick();
    bif.dfi_rddata_valid = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: observed %0d beats outstanding expected 0", exp_q.size());
    end
  endtask

  // R-channel monitor: whatever is presented must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bif.rvalid) begin
      if (exp_q.size() == 0) begin
        chk("r_unexpected", 64'(bif.rvalid), 64'd0);
      end else begin
        chk("rid",   64'(bif.rid),   64'(exp_q[0].id));
        chk("rdata", bif.rdata,      exp_q[0].data);
        chk("rlast", 64'(bif.rlast), 64'(exp_q[0].last));
        chk("rresp", 64'(bif.rresp), 64'd0);
        if (bif.rready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.rd_issue_valid   = 1'b0;
    bif.rd_issue_id      = '0;
    bif.rd_issue_len     = '0;
    bif.dfi_rddata_valid = 1'b0;
    bif.dfi_rddata       = '0;
    bif.rready           = 1'b0;
    tick();
    tick();
    chk("rst_rvalid",  64'(bif.rvalid), 64'd0);
    chk("rst_rlast",   64'(bif.rlast),  64'd0);
    chk("rst_rid",     64'(bif.rid),    64'd0);
    chk("rst_rdata",   bif.rdata,       64'd0);
    chk("rst_ovf",     64'(bif.err_overflow), 64'd0);
    chk("rst_orphan",  64'(bif.err_orphan),   64'd0);
    chk("rst_ready",   64'(bif.rd_issue_ready), 64'd1);
    rst = 1'b0;
    tick();

    // single read id=3 len=3, one-cycle capture latency
    bif.rready = 1'b1;
    issue(4'd3, 4'd3);
    beat(64'hA0A0_0000_0000_00A0);
    chk("latency_rvalid", 64'(bif.rvalid), 64'd1);
    beat(64'hA1A1_0000_0000_00A1);
    beat(64'hA2A2_0000_0000_00A2);
    beat(64'hA3A3_0000_0000_00A3);
    drain_wait();

    // back-to-back bursts fill the reservation; one handshake reopens it
    bif.rready = 1'b0;
    issue(4'd1, 4'd7);
    issue(4'd2, 4'd7);
    bif.rd_issue_valid = 1'b1;
    bif.rd_issue_id    = 4'd4;
    bif.rd_issue_len   = 4'd0;
    chk("resv_full_ready", 64'(bif.rd_issue_ready), 64'd0);
    bif.rd_issue_valid = 1'b0;
    for (int i = 0; i < 8; i++) beat({32'h1111_0000, 32'(i)});
    bif.rready = 1'b1;
    tick();
    bif.rready = 1'b0;
    bif.rd_issue_len = 4'd0;
    chk("resv_freed_ready", 64'(bif.rd_issue_ready), 64'd1);
    issue(4'd4, 4'd0);
    for (int i = 0; i < 8; i++) beat({32'h2222_0000, 32'(i)});
    beat(64'h4444_4444_4444_4444);
    chk("b2b_ovf", 64'(bif.err_overflow), 64'd0);
    bif.rready = 1'b1;
    drain_wait();

    // 16 beats buffered with rready low, then 16-cycle drain
    bif.rready = 1'b0;
    issue(4'd6, 4'd15);
    for (int i = 0; i < 16; i++) beat({$urandom, $urandom});
    chk("full_ovf",    64'(bif.err_overflow), 64'd0);
    chk("full_rvalid", 64'(bif.rvalid), 64'd1);
    bif.rready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("drain15_rvalid", 64'(bif.rvalid), 64'd1);
    tick();
    chk("drain16_rvalid", 64'(bif.rvalid), 64'd0);
    drain_wait();

    // rready toggling during a 16-beat burst
    issue(4'd7, 4'd15);
    for (int i = 0; i < 16; i++) begin
      bif.rready = (i % 2 == 1);
      beat({$urandom, $urandom});
    end
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      bif.rready = ~bif.rready;
      tick();
    end
    bif.rready = 1'b1;
    drain_wait();
    chk("toggle_ovf", 64'(bif.err_overflow), 64'd0);

    // orphan beat
    beat(64'hDEAD_BEEF_DEAD_BEEF);
    chk("orphan_flag",   64'(bif.err_orphan), 64'd1);
    chk("orphan_rvalid", 64'(bif.rvalid),     64'd0);
    tick();
    tick();
    chk("orphan_sticky", 64'(bif.err_orphan), 64'd1);
    issue(4'd8, 4'd1);
    beat(64'h8888_0000_0000_0001);
    beat(64'h8888_0000_0000_0002);
    drain_wait();
    chk("post_orphan_flag", 64'(bif.err_orphan), 64'd1);

    // reset mid-burst after 2 of 4 beats delivered
    issue(4'd9, 4'd3);
    beat(64'h9999_0000_0000_0000);
    beat(64'h9999_0000_0000_0001);
    drain_wait();
    bif.rready = 1'b0;
    beat(64'h9999_0000_0000_0002);
    chk("pre_rst_rvalid", 64'(bif.rvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rvalid", 64'(bif.rvalid), 64'd0);
    exp_q.delete();
    tag_q.delete();
    mcnt = 0;
    tick();
    rst = 1'b0;
    tick();
    bif.rd_issue_len = 4'd15;
    chk("post_rst_ready",  64'(bif.rd_issue_ready), 64'd1);
    chk("post_rst_orphan", 64'(bif.err_orphan), 64'd0);
    chk("post_rst_rvalid", 64'(bif.rvalid), 64'd0);
    bif.rready = 1'b1;
    issue(4'd5, 4'd0);
    beat(64'h5555_5555_0000_0005);
    drain_wait();
    chk("final_ovf", 64'(bif.err_overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
